// File: rtl/arith_sched.sv
// Round-robin scheduler sharing one cube-root and one square-root unit between two requesters.
// Each job computes y = sqrt(a + cbrt(b)) by sequencing the units through their start/busy handshakes.
module arith_sched #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] a0_bi,
    input  logic [WIDTH-1:0] b0_bi,
    input  logic [WIDTH-1:0] a1_bi,
    input  logic [WIDTH-1:0] b1_bi,
    output logic             busy0_o,
    output logic             busy1_o,
    output logic             done0_o,
    output logic             done1_o,
    output logic             err0_o,
    output logic             err1_o,
    output logic [WIDTH-1:0] y0_bo,
    output logic [WIDTH-1:0] y1_bo,
    output logic             cube_start_o,
    output logic [WIDTH-1:0] cube_x_bo,
    input  logic             cube_busy_i,
    input  logic [WIDTH-1:0] cube_y_bi,
    output logic             sqrt_start_o,
    output logic [WIDTH-1:0] sqrt_x_bo,
    input  logic             sqrt_busy_i,
    input  logic [WIDTH-1:0] sqrt_y_bi
);

    localparam int unsigned CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        CUBE_GO,
        CUBE_ARM,
        CUBE_WAIT,
        SQRT_GO,
        SQRT_ARM,
        SQRT_WAIT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [CW-1:0]    wait_q, wait_d;
    logic [CW-1:0]    wait_inc;
    logic             gnt;

    logic             busy0_d, busy1_d, done0_d, done1_d, err0_d, err1_d;
    logic             cube_start_d, sqrt_start_d;
    logic [WIDTH-1:0] y0_d, y1_d, cube_x_d, sqrt_x_d;

    // Next-state and next-output logic; start/done/err are pulses, everything else holds.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        a_d          = a_q;
        wait_d       = wait_q;
        busy0_d      = busy0_o;
        busy1_d      = busy1_o;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        y0_d         = y0_bo;
        y1_d         = y1_bo;
        cube_start_d = 1'b0;
        cube_x_d     = cube_x_bo;
        sqrt_start_d = 1'b0;
        sqrt_x_d     = sqrt_x_bo;
        wait_inc     = wait_q + CW'(1);
        gnt          = (req0_i && req1_i) ? ptr_q : req1_i;

        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    owner_d      = gnt;
                    ptr_d        = ~gnt;
                    a_d          = gnt ? a1_bi : a0_bi;
                    cube_x_d     = gnt ? b1_bi : b0_bi;
                    busy0_d      = ~gnt;
                    busy1_d      = gnt;
                    cube_start_d = 1'b1;
                    state_d      = CUBE_GO;
                end
            end
            CUBE_GO: begin
                wait_d  = '0;
                state_d = CUBE_ARM;
            end
            CUBE_ARM: begin
                state_d = CUBE_WAIT;
            end
            CUBE_WAIT: begin
                if (!cube_busy_i) begin
                    sqrt_x_d     = WIDTH'(a_q + cube_y_bi);
                    sqrt_start_d = 1'b1;
                    state_d      = SQRT_GO;
                end else if (wait_inc == CW'(WAIT_MAX)) begin
                    err0_d  = ~owner_q;
                    err1_d  = owner_q;
                    busy0_d = 1'b0;
                    busy1_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_inc;
                end
            end
            SQRT_GO: begin
                wait_d  = '0;
                state_d = SQRT_ARM;
            end
            SQRT_ARM: begin
                state_d = SQRT_WAIT;
            end
            SQRT_WAIT: begin
                if (!sqrt_busy_i) begin
                    if (owner_q) begin
                        y1_d    = sqrt_y_bi;
                        done1_d = 1'b1;
                    end else begin
                        y0_d    = sqrt_y_bi;
                        done0_d = 1'b1;
                    end
                    state_d = DONE;
                end else if (wait_inc == CW'(WAIT_MAX)) begin
                    err0_d  = ~owner_q;
                    err1_d  = owner_q;
                    busy0_d = 1'b0;
                    busy1_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_inc;
                end
            end
            DONE: begin
                busy0_d = 1'b0;
                busy1_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any job silently.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            a_q          <= '0;
            wait_q       <= '0;
            busy0_o      <= 1'b0;
            busy1_o      <= 1'b0;
            done0_o      <= 1'b0;
            done1_o      <= 1'b0;
            err0_o       <= 1'b0;
            err1_o       <= 1'b0;
            y0_bo        <= '0;
            y1_bo        <= '0;
            cube_start_o <= 1'b0;
            cube_x_bo    <= '0;
            sqrt_start_o <= 1'b0;
            sqrt_x_bo    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            wait_q       <= wait_d;
            busy0_o      <= busy0_d;
            busy1_o      <= busy1_d;
            done0_o      <= done0_d;
            done1_o      <= done1_d;
            err0_o       <= err0_d;
            err1_o       <= err1_d;
            y0_bo        <= y0_d;
            y1_bo        <= y1_d;
            cube_start_o <= cube_start_d;
            cube_x_bo    <= cube_x_d;
            sqrt_start_o <= sqrt_start_d;
            sqrt_x_bo    <= sqrt_x_d;
        end
    end

endmodule

// File: tb/tb_arith_sched.sv
// Bench for arith_sched: mock cube/sqrt units with programmable busy length, directed table,
// multi-cycle corner sequences and a randomized run against a round-robin reference model.
module tb_arith_sched;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       req0_i = 1'b0, req1_i = 1'b0;
    logic [7:0] a0_bi = '0, b0_bi = '0, a1_bi = '0, b1_bi = '0;
    logic       busy0_o, busy1_o, done0_o, done1_o, err0_o, err1_o;
    logic [7:0] y0_bo, y1_bo;
    logic       cube_start_o, sqrt_start_o;
    logic [7:0] cube_x_bo, sqrt_x_bo;
    logic       cube_busy_i, sqrt_busy_i;
    logic [7:0] cube_y_bi, sqrt_y_bi;

    arith_sched #(.WIDTH(8), .WAIT_MAX(10)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .req1_i(req1_i),
        .a0_bi(a0_bi), .b0_bi(b0_bi), .a1_bi(a1_bi), .b1_bi(b1_bi),
        .busy0_o(busy0_o), .busy1_o(busy1_o),
        .done0_o(done0_o), .done1_o(done1_o),
        .err0_o(err0_o), .err1_o(err1_o),
        .y0_bo(y0_bo), .y1_bo(y1_bo),
        .cube_start_o(cube_start_o), .cube_x_bo(cube_x_bo),
        .cube_busy_i(cube_busy_i), .cube_y_bi(cube_y_bi),
        .sqrt_start_o(sqrt_start_o), .sqrt_x_bo(sqrt_x_bo),
        .sqrt_busy_i(sqrt_busy_i), .sqrt_y_bi(sqrt_y_bi)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    function automatic int icbrt(input int x);
        int r = 0;
        for (int i = 0; i < 8; i++) if (i * i * i <= x) r = i;
        return r;
    endfunction

    function automatic int isqrt(input int x);
        int r = 0;
        for (int i = 0; i < 17; i++) if (i * i <= x) r = i;
        return r;
    endfunction

    function automatic int ref_y(input int a, input int b);
        return isqrt((a + icbrt(b)) % 256);
    endfunction

    // Mock units: busy high from the cycle after start for lc+1 / ls+1 cycles.
    int         lc_cfg = 0, ls_cfg = 0;
    bit         cube_stuck = 1'b0;
    int         cube_cnt = 0, sqrt_cnt = 0;
    logic [7:0] cube_y = '0, sqrt_y = '0;
    int         cube_starts = 0, sqrt_starts = 0, overlap = 0;
    logic [7:0] last_cube_x = '0, last_sqrt_x = '0;

    assign cube_busy_i = cube_stuck || (cube_cnt != 0);
    assign sqrt_busy_i = (sqrt_cnt != 0);
    assign cube_y_bi   = cube_y;
    assign sqrt_y_bi   = sqrt_y;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (cube_start_o && sqrt_start_o) overlap <= overlap + 1;
        if (cube_start_o) begin
            cube_cnt    <= lc_cfg + 1;
            cube_y      <= 8'(icbrt(int'(cube_x_bo)));
            cube_starts <= cube_starts + 1;
            last_cube_x <= cube_x_bo;
        end else if (cube_cnt > 0) begin
            cube_cnt <= cube_cnt - 1;
        end
        if (sqrt_start_o) begin
            sqrt_cnt    <= ls_cfg + 1;
            sqrt_y      <= 8'(isqrt(int'(sqrt_x_bo)));
            sqrt_starts <= sqrt_starts + 1;
            last_sqrt_x <= sqrt_x_bo;
        end else if (sqrt_cnt > 0) begin
            sqrt_cnt <= sqrt_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {24'd0, busy0_o, busy1_o, done0_o, done1_o, err0_o, err1_o,
                cube_start_o, sqrt_start_o, y0_bo, y1_bo, cube_x_bo, sqrt_x_bo};
    endfunction

    function automatic logic busy_of(input int w);
        return (w != 0) ? busy1_o : busy0_o;
    endfunction
    function automatic logic done_of(input int w);
        return (w != 0) ? done1_o : done0_o;
    endfunction
    function automatic int y_of(input int w);
        return (w != 0) ? int'(y1_bo) : int'(y0_bo);
    endfunction

    task automatic drive_req(input int w, input int a, input int b);
        if (w != 0) begin a1_bi = 8'(a); b1_bi = 8'(b); req1_i = 1'b1; end
        else        begin a0_bi = 8'(a); b0_bi = 8'(b); req0_i = 1'b1; end
    endtask

    task automatic scramble();
        req0_i = 1'b0; req1_i = 1'b0;
        a0_bi = 8'($urandom); b0_bi = 8'($urandom);
        a1_bi = 8'($urandom); b1_bi = 8'($urandom);
    endtask

    // Wait (bounded) until either busy rises; reports owner and grant cycle.
    task automatic wait_grant(output int owner, output int t0, output bit ok);
        ok = 1'b0; owner = 0; t0 = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk_i);
            if (busy0_o || busy1_o) begin ok = 1'b1; owner = busy1_o ? 1 : 0; t0 = cyc; end
        end
    endtask

    task automatic wait_done(input int w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_i);
            if (done_of(w)) ok = 1'b1;
        end
    endtask

    task automatic run_job(input string tag, input int w, input int a, input int b,
                           input int lc, input int ls, input int exp_sum, input int exp_y);
        int  owner, t0, cs0, ss0;
        bit  ok;
        @(negedge clk_i);
        lc_cfg = lc; ls_cfg = ls;
        drive_req(w, a, b);
        wait_grant(owner, t0, ok);
        check({tag, " grant"}, {63'd0, ok}, 64'd1);
        if (!ok) begin scramble(); return; end
        check({tag, " owner"}, 64'(owner), 64'(w));
        cs0 = cube_starts; ss0 = sqrt_starts;
        scramble();
        wait_done(w, ok);
        check({tag, " done"}, {63'd0, ok}, 64'd1);
        if (!ok) return;
        check({tag, " latency"}, 64'(cyc - t0), 64'(lc + ls + 6));
        check({tag, " y"}, 64'(y_of(w)), 64'(exp_y));
        check({tag, " cube_x"}, 64'(last_cube_x), 64'(b));
        check({tag, " sqrt_x"}, 64'(last_sqrt_x), 64'(exp_sum));
        check({tag, " starts"}, 64'((cube_starts - cs0) * 16 + (sqrt_starts - ss0)), 64'(17));
        @(negedge clk_i);
        check({tag, " done/busy after"}, {62'd0, done_of(w), busy_of(w)}, 64'd0);
    endtask

    typedef struct {
        string name;
        int    who, a, b, lc, ls, exp_sum, exp_y;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int  owner, t0, pm, exp_owner, nz, pulses, y0_prev;
        int  ra0, rb0, ra1, rb1, r, lc, ls;
        int  ca[2], cb[2];
        bit  ok;

        vecs[0] = '{"single",  0,   3,  27, 4, 4,   6,  2};
        vecs[1] = '{"wrap1",   1, 255,   8, 1, 2,   1,  1};
        vecs[2] = '{"wrap255", 1, 250, 125, 3, 0, 255, 15};
        vecs[3] = '{"zero",    0,   0,   0, 0, 0,   0,  0};
        vecs[4] = '{"max",     0, 255, 255, 6, 5,   5,  2};
        vecs[5] = '{"mid",     1, 100,  64, 2, 6, 104, 10};
        vecs[6] = '{"b255",    0,   0, 255, 1, 1,   6,  2};

        // Reset and defaults
        repeat (3) @(negedge clk_i);
        check("reset outputs", all_outs(), 64'd0);
        rst_i = 1'b1;
        nz = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (all_outs() != 64'd0) nz++;
        end
        check("idle quiet", 64'(nz + cube_starts + sqrt_starts), 64'd0);

        // Directed table
        for (int i = 0; i < 7; i++)
            run_job(vecs[i].name, vecs[i].who, vecs[i].a, vecs[i].b,
                    vecs[i].lc, vecs[i].ls, vecs[i].exp_sum, vecs[i].exp_y);

        // Contention: both held, grants alternate from requester 0 after reset
        @(negedge clk_i); rst_i = 1'b0;
        @(negedge clk_i); rst_i = 1'b1;
        lc_cfg = 2; ls_cfg = 3;
        ca[0] = 10; cb[0] = 64; ca[1] = 20; cb[1] = 1;
        drive_req(0, ca[0], cb[0]);
        drive_req(1, ca[1], cb[1]);
        for (int k = 0; k < 4; k++) begin
            wait_grant(owner, t0, ok);
            check("contend grant", {63'd0, ok}, 64'd1);
            if (!ok) break;
            check("contend owner", 64'(owner), 64'(k % 2));
            wait_done(owner, ok);
            check("contend done", {63'd0, ok}, 64'd1);
            if (!ok) break;
            check("contend y", 64'(y_of(owner)), 64'(ref_y(ca[owner], cb[owner])));
            if (k == 3) begin req0_i = 1'b0; req1_i = 1'b0; end
            @(negedge clk_i);
        end
        req0_i = 1'b0; req1_i = 1'b0;
        @(negedge clk_i);
        check("contend idle", {62'd0, busy0_o, busy1_o}, 64'd0);

        // Randomized run against round-robin model
        @(negedge clk_i); rst_i = 1'b0;
        @(negedge clk_i); rst_i = 1'b1;
        pm = 0;
        for (int it = 0; it < 25; it++) begin
            r = int'($urandom_range(3, 1));
            ra0 = int'($urandom_range(255, 0)); rb0 = int'($urandom_range(255, 0));
            ra1 = int'($urandom_range(255, 0)); rb1 = int'($urandom_range(255, 0));
            lc = int'($urandom_range(6, 0)); ls = int'($urandom_range(6, 0));
            lc_cfg = lc; ls_cfg = ls;
            if (r[0]) drive_req(0, ra0, rb0);
            if (r[1]) drive_req(1, ra1, rb1);
            exp_owner = (r == 3) ? pm : (r[1] ? 1 : 0);
            pm = 1 - exp_owner;
            wait_grant(owner, t0, ok);
            check("rand grant", {63'd0, ok}, 64'd1);
            if (!ok) begin scramble(); continue; end
            check("rand owner", 64'(owner), 64'(exp_owner));
            scramble();
            wait_done(exp_owner, ok);
            check("rand done", {63'd0, ok}, 64'd1);
            if (!ok) continue;
            check("rand latency", 64'(cyc - t0), 64'(lc + ls + 6));
            check("rand y", 64'(y_of(exp_owner)),
                  64'(exp_owner != 0 ? ref_y(ra1, rb1) : ref_y(ra0, rb0)));
            @(negedge clk_i);
        end

        // Timeout on a stuck cube unit
        run_job("pre-timeout", 0, 3, 27, 1, 1, 6, 2);
        y0_prev = 2;
        cube_stuck = 1'b1;
        drive_req(0, 77, 200);
        wait_grant(owner, t0, ok);
        check("timeout grant", {63'd0, ok}, 64'd1);
        scramble();
        ok = 1'b0; pulses = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk_i);
            if (done0_o) pulses++;
            if (err0_o) ok = 1'b1;
        end
        check("timeout err", {63'd0, ok}, 64'd1);
        check("timeout y0 held", 64'(y0_bo), 64'(y0_prev));
        check("timeout busy0", {63'd0, busy0_o}, 64'd0);
        repeat (10) begin
            @(negedge clk_i);
            if (err0_o || done0_o) pulses++;
        end
        check("timeout single pulse", 64'(pulses), 64'd0);
        cube_stuck = 1'b0;
        run_job("after-timeout", 1, 250, 125, 2, 2, 255, 15);

        // Reset during SQRT_WAIT
        lc_cfg = 1; ls_cfg = 6;
        drive_req(0, 100, 64);
        wait_grant(owner, t0, ok);
        check("midrst grant", {63'd0, ok}, 64'd1);
        scramble();
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk_i);
            if (sqrt_start_o) ok = 1'b1;
        end
        check("midrst sqrt start", {63'd0, ok}, 64'd1);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst outputs", all_outs(), 64'd0);
        rst_i = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (done0_o || done1_o || err0_o || err1_o) pulses++;
        end
        check("midrst no pulse", 64'(pulses), 64'd0);
        run_job("after-reset", 0, 100, 64, 2, 2, 104, 10);

        check("start overlap", 64'(overlap), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
